snake_dir_ctrl: RTL and testbench
=================================

Name: snake_dir_ctrl

Overview:
- Consumes the four debounced button-activity levels (up/right/down/left) and turns each rising edge into a direction request.
- Queues up to two legal turn requests.
- Commits one request per game step tick, producing the snake's current heading for the game-logic/movement stage.
- Rejects 180° reversals and duplicate requests, so two quick presses between steps are both honoured in order.

Parameters:
- RESET_DIR, 2'd1, heading loaded on reset and on restart (0=up, 1=right, 2=down, 3=left).
- Q_DEPTH, 2, request queue depth; fixed at 2, and the implementation need not support other values.

Ports:
- clk  input  1  system clock (same domain as the debouncers).
- rst_n  input  1  asynchronous active-low reset.
- btn_act  input  4  debounced activity levels; bit0 up, bit1 right, bit2 down, bit3 left; high while pressed.
- game_tick  input  1  one-cycle pulse; snake advances one cell.
- restart  input  1  synchronous clear, same effect as reset.
- dir  output  2  committed heading.
- dir_changed  output  1  one-cycle pulse when dir takes a new value.
- q_count  output  2  queued requests (0..2).
- req_drop  output  1  one-cycle pulse when a legal request is discarded because the queue is full.

Behaviour:
Reset and restart:
- On rst_n low (async) or restart high (sync, next edge): dir=RESET_DIR, queue empty, q_count=0, dir_changed=0, req_drop=0.
- On reset, the edge-detect history btn_prev is set to 4'b1111.
  - Debouncer outputs sit high after power-up, so this blocks a spurious request.
  - The first request needs each line to fall and rise again.

Edge detection:
- rise = btn_act & ~btn_prev; btn_prev <= btn_act every cycle.
- More than one rise bit in a cycle: the lowest index wins and the others are ignored; no drop pulse for the ignored bits.
- A held button produces exactly one request.

Reference heading (ref), used for validation:
- Tail of the queue after this cycle's pop, if the queue is non-empty.
- Otherwise, the value dir takes at the end of this cycle.

Request legality:
- Candidate r is legal iff r != ref and r != ref^2'b10, i.e. not the same and not opposite.
- Illegal requests are silently discarded: no pulse, no state change.

Queue:
- 2-entry FIFO: head = entry 0.
- Push: a legal request is appended when the queue is not full after this cycle's pop.

game_tick:
- If the queue is non-empty: dir <= head, pop, and dir_changed=1 on the following cycle (registered).
- The popped head is always != dir, by legality.
- If the queue is empty: dir holds and dir_changed=0.

Same-cycle tick and request:
- Pop first, then validate and push against the post-pop ref.
- A full queue plus tick plus a legal request: pop and push both happen, q_count stays 2, no drop.

Full queue without tick:
- A legal request is discarded, and req_drop=1 on the next cycle.

Output timing:
- All outputs are registered.
- dir and q_count update on the edge following the triggering inputs.
- dir_changed and req_drop are valid one cycle after the edge that caused them and are high for exactly one cycle.

Test Plan:
- Reset with btn_act=4'b1111 held for 10 cycles, then game_tick -> dir=1, q_count=0, no dir_changed.
- From dir=1, after lines idle low: pulse up (bit0) rise, then game_tick -> q_count 1 then 0, dir=0, dir_changed single pulse.
- Reversal rejection, from dir=1: left (bit3) rise, then right (bit1) rise -> q_count stays 0; game_tick leaves dir=1.
- Two turns, from dir=1 with no tick between: down, then left -> q_count=2; tick 1 gives dir=2, tick 2 gives dir=3.
- Full queue with another legal request, no tick -> req_drop one pulse, q_count=2, queue contents unchanged.
- Full queue, same-cycle game_tick and legal request -> head pops to dir, new entry validated against the remaining tail, q_count=2, no req_drop.
- Simultaneous rise on bits 0 and 2 with dir=1 -> only up queued.
- rst_n asserted mid-operation with q_count=2 -> immediate dir=RESET_DIR, q_count=0.

Source files
------------

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns button rising edges into queued, legality-checked heading changes committed on game ticks.
module snake_dir_ctrl #(
  parameter logic [1:0] RESET_DIR = 2'd1,
  parameter int Q_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_act,
  input  logic       game_tick,
  input  logic       restart,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic [1:0] q_count,
  output logic       req_drop
);
  logic [3:0] btn_prev, rise;
  logic [1:0] q0, q1, q0_p, cnt_p, dir_n, ref_dir, req;
  logic       pop, legal, full, push, drop;
  always_comb begin
    rise    = btn_act & ~btn_prev;
    pop     = game_tick && q_count != 2'd0;
    cnt_p   = q_count - {1'b0, pop};
    q0_p    = pop ? q1 : q0;
    dir_n   = pop ? q0 : dir;
    // validate against the newest pending heading, or the heading about to be committed
    ref_dir = cnt_p == 2'd2 ? q1 : cnt_p == 2'd1 ? q0_p : dir_n;
    req     = rise[0] ? 2'd0 : rise[1] ? 2'd1 : rise[2] ? 2'd2 : 2'd3;
    legal   = |rise && req != ref_dir && req != (ref_dir ^ 2'b10);
    full    = cnt_p == 2'(Q_DEPTH);
    push    = legal && !full;
    drop    = legal && full;
  end
  // btn_prev starts high so lines already high after power-up raise no request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev    <= 4'b1111;
      dir         <= RESET_DIR;
      dir_changed <= 1'b0;
      q_count     <= 2'd0;
      req_drop    <= 1'b0;
      q0          <= 2'd0;
      q1          <= 2'd0;
    end else if (restart) begin
      btn_prev    <= 4'b1111;
      dir         <= RESET_DIR;
      dir_changed <= 1'b0;
      q_count     <= 2'd0;
      req_drop    <= 1'b0;
      q0          <= 2'd0;
      q1          <= 2'd0;
    end else begin
      btn_prev    <= btn_act;
      dir         <= dir_n;
      dir_changed <= pop;
      req_drop    <= drop;
      q_count     <= cnt_p + {1'b0, push};
      q0          <= (push && cnt_p == 2'd0) ? req : q0_p;
      q1          <= (push && cnt_p == 2'd1) ? req : q1;
    end
  end
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: vector table, corner sequences and a queue-based model under random stimulus.
module tb_snake_dir_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_act = 4'hF;
  logic       game_tick = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] dir, q_count;
  logic       dir_changed, req_drop;
  int n_chk = 0;
  int n_err = 0;

  snake_dir_ctrl #(.RESET_DIR(2'd1), .Q_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_act(btn_act), .game_tick(game_tick),
    .restart(restart), .dir(dir), .dir_changed(dir_changed),
    .q_count(q_count), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       tick, rs;
    logic [1:0] d, q;
    logic       c, dr;
  } vec_t;

  function automatic vec_t v(int b, int t, int r, int d, int q, int c, int x);
    vec_t e;
    e.btn = 4'(b); e.tick = 1'(t); e.rs = 1'(r);
    e.d = 2'(d); e.q = 2'(q); e.c = 1'(c); e.dr = 1'(x);
    return e;
  endfunction

  // reference model: the pending turns as a plain queue
  int m_dir;
  int mq[$];
  logic [3:0] m_prev;
  int m_chg, m_drop;

  task automatic model_reset();
    m_dir = 1; mq.delete(); m_prev = 4'hF; m_chg = 0; m_drop = 0;
  endtask

  task automatic model_step();
    logic [3:0] rise;
    int r, rd;
    if (restart) begin
      model_reset();
      return;
    end
    rise = btn_act & ~m_prev;
    m_prev = btn_act;
    m_chg = 0; m_drop = 0;
    if (game_tick && mq.size() > 0) begin
      m_dir = mq.pop_front();
      m_chg = 1;
    end
    if (rise != 0) begin
      r = 0;
      while (!rise[r]) r++;
      rd = mq.size() > 0 ? mq[$] : m_dir;
      // a legal request is a quarter turn: odd distance round the compass
      if (((r + 4 - rd) % 2) == 1) begin
        if (mq.size() < 2) mq.push_back(r);
        else m_drop = 1;
      end
    end
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(logic [3:0] b, logic t, logic r);
    @(negedge clk);
    btn_act = b; game_tick = t; restart = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".dir"}, int'(dir), m_dir);
    chk({tag, ".q_count"}, int'(q_count), mq.size());
    chk({tag, ".dir_changed"}, int'(dir_changed), m_chg);
    chk({tag, ".req_drop"}, int'(req_drop), m_drop);
  endtask

  vec_t tbl[34];

  initial begin
    tbl[0]  = v(4'hF,1,0, 1,0,0,0);
    tbl[1]  = v(4'h0,0,0, 1,0,0,0);
    tbl[2]  = v(4'h1,0,0, 1,1,0,0);
    tbl[3]  = v(4'h0,1,0, 0,0,1,0);
    tbl[4]  = v(4'h0,0,0, 0,0,0,0);
    tbl[5]  = v(4'h2,0,0, 0,1,0,0);
    tbl[6]  = v(4'h0,1,0, 1,0,1,0);
    tbl[7]  = v(4'h0,0,0, 1,0,0,0);
    tbl[8]  = v(4'h8,0,0, 1,0,0,0);
    tbl[9]  = v(4'h0,0,0, 1,0,0,0);
    tbl[10] = v(4'h2,0,0, 1,0,0,0);
    tbl[11] = v(4'h0,1,0, 1,0,0,0);
    tbl[12] = v(4'h4,0,0, 1,1,0,0);
    tbl[13] = v(4'h0,0,0, 1,1,0,0);
    tbl[14] = v(4'h8,0,0, 1,2,0,0);
    tbl[15] = v(4'h0,0,0, 1,2,0,0);
    tbl[16] = v(4'h1,0,0, 1,2,0,1);
    tbl[17] = v(4'h0,0,0, 1,2,0,0);
    tbl[18] = v(4'h1,1,0, 2,2,1,0);
    tbl[19] = v(4'h0,1,0, 3,1,1,0);
    tbl[20] = v(4'h0,1,0, 0,0,1,0);
    tbl[21] = v(4'h0,0,0, 0,0,0,0);
    tbl[22] = v(4'h2,0,0, 0,1,0,0);
    tbl[23] = v(4'h0,1,0, 1,0,1,0);
    tbl[24] = v(4'h5,0,0, 1,1,0,0);
    tbl[25] = v(4'h0,1,0, 0,0,1,0);
    tbl[26] = v(4'h8,0,0, 0,1,0,0);
    tbl[27] = v(4'h0,0,1, 1,0,0,0);
    tbl[28] = v(4'h0,1,0, 1,0,0,0);
    tbl[29] = v(4'h4,0,0, 1,1,0,0);
    tbl[30] = v(4'hC,0,0, 1,2,0,0);
    tbl[31] = v(4'hC,1,0, 2,1,1,0);
    tbl[32] = v(4'h0,1,0, 3,0,1,0);
    tbl[33] = v(4'h0,0,0, 3,0,0,0);

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.dir", int'(dir), 1);
    chk("reset.q_count", int'(q_count), 0);
    chk("reset.dir_changed", int'(dir_changed), 0);
    chk("reset.req_drop", int'(req_drop), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(4'hF, 1'b0, 1'b0);
      chk("hold.q_count", int'(q_count), 0);
    end

    for (int i = 0; i < 34; i++) begin
      step(tbl[i].btn, tbl[i].tick, tbl[i].rs);
      chk($sformatf("vec%0d.dir", i), int'(dir), int'(tbl[i].d));
      chk($sformatf("vec%0d.q_count", i), int'(q_count), int'(tbl[i].q));
      chk($sformatf("vec%0d.dir_changed", i), int'(dir_changed), int'(tbl[i].c));
      chk($sformatf("vec%0d.req_drop", i), int'(req_drop), int'(tbl[i].dr));
    end

    // fill the queue, then pull rst_n low between clock edges
    step(4'h1, 1'b0, 1'b0);
    step(4'h2, 1'b0, 1'b0);
    chk("prereset.q_count", int'(q_count), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async.dir", int'(dir), 1);
    chk("async.q_count", int'(q_count), 0);
    model_reset();
    @(negedge clk);
    btn_act = 4'hF; game_tick = 1'b0; restart = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        step(4'h0, 1'b0, 1'b1);
        chk_model("rand");
        step(4'h0, 1'b0, 1'b0);
      end else begin
        step(4'($urandom), 1'($urandom_range(0, 2) == 0), 1'b0);
      end
      chk_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
